// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC phase-detector measurement controller:
//   - N_TDC  : thermometer code length of the UP/DWN TDC lines
//   - CNT_W  : width of a popcount result (0..N_TDC)
//   - ERR_W  : width of the signed phase error (-N_TDC..+N_TDC)
//   - tdc_state_e : controller state encoding, visible on the state output
//   - abs_err : magnitude of a signed phase error
// -----------------------------------------------------------------------------
package tdc_pkg;

    localparam int unsigned N_TDC = 32;
    localparam int unsigned CNT_W = $clog2(N_TDC + 1);
    localparam int unsigned ERR_W = $clog2(N_TDC) + 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StTrack  = 2'd2,
        StLocked = 2'd3
    } tdc_state_e;

    // The error never reaches -2**(ERR_W-1), so negation cannot overflow.
    function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
        return e[ERR_W-1] ? ERR_W'(-e) : ERR_W'(e);
    endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// -----------------------------------------------------------------------------
// tdc_therm2bin
// Registered popcount of a thermometer code. Counting ones rather than
// locating the top transition makes the result tolerant of bubbles.
// Latency: 1 clk.
//
// Ports:
//   clk     in   sampling clock
//   reset   in   synchronous, active-high
//   code_i  in   W-bit thermometer code
//   count_o out  number of ones in code_i, registered
// -----------------------------------------------------------------------------
module tdc_therm2bin #(
    parameter int unsigned W  = 32,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  code_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(W); i++) begin
            count_d = count_d + CW'(code_i[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tdc_pd_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_pd_ctrl
// Measurement controller for the thermometer-coded TDC phase detector.
// Once per reference period the peak UP and DWN counts seen in the window are
// turned into a signed phase error with a one-cycle valid strobe. The block
// sequences settle/track/lock phases, runs the lock detector and flags loss
// of the reference.
//
// Pipeline:
//   stage 1 : popcount of both codes, ref_edge delayed to ref_d_q
//   stage 2 : peak tracking; window close on ref_d_q -> registered outputs
//   err_valid therefore follows the ref_edge input by exactly 2 clk.
//
// Ports:
//   clk        in   TDC sampling clock
//   reset      in   synchronous, active-high
//   enable     in   run controller; low forces IDLE
//   ref_edge   in   one-cycle pulse per reference rising edge (clk domain)
//   up_error   in   UP thermometer code
//   dwn_error  in   DWN thermometer code
//   phase_err  out  signed up_peak - dwn_peak, held between strobes
//   err_valid  out  one-cycle strobe qualifying phase_err
//   err_sat    out  a peak of the strobed measurement equalled N_TDC
//   locked     out  lock indicator
//   ref_lost   out  sticky reference timeout, cleared by the next ref_edge
//   state      out  IDLE=0, SETTLE=1, TRACK=2, LOCKED=3
// -----------------------------------------------------------------------------
module tdc_pd_ctrl
    import tdc_pkg::*;
#(
    parameter int unsigned SETTLE_PERIODS = 4,
    parameter int unsigned LOCK_TOL       = 2,
    parameter int unsigned UNLOCK_TOL     = 4,
    parameter int unsigned LOCK_COUNT     = 16,
    parameter int unsigned REF_TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    ref_edge,
    input  logic [N_TDC-1:0]        up_error,
    input  logic [N_TDC-1:0]        dwn_error,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    err_valid,
    output logic                    err_sat,
    output logic                    locked,
    output logic                    ref_lost,
    output logic [1:0]              state
);

    localparam int unsigned SET_W = $clog2(SETTLE_PERIODS + 1);
    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned TMO_W = $clog2(REF_TIMEOUT + 1);

    localparam logic [SET_W-1:0] SettleLast = SET_W'(SETTLE_PERIODS - 1);
    localparam logic [RUN_W-1:0] RunLock    = RUN_W'(LOCK_COUNT);
    localparam logic [TMO_W-1:0] TmoMax     = TMO_W'(REF_TIMEOUT);
    localparam logic [TMO_W-1:0] TmoLast    = TMO_W'(REF_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntFull    = CNT_W'(N_TDC);

    // Stage 1
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dwn_cnt;
    logic             ref_d_d, ref_d_q;

    // Stage 2 and control state
    logic [CNT_W-1:0]        up_peak_d, up_peak_q;
    logic [CNT_W-1:0]        dwn_peak_d, dwn_peak_q;
    tdc_state_e              state_d, state_q;
    logic [SET_W-1:0]        settle_d, settle_q;
    logic [RUN_W-1:0]        run_d, run_q;
    logic [TMO_W-1:0]        tmo_d, tmo_q;
    logic signed [ERR_W-1:0] phase_err_d, phase_err_q;
    logic                    err_valid_d, err_valid_q;
    logic                    err_sat_d, err_sat_q;
    logic                    locked_d, locked_q;
    logic                    ref_lost_d, ref_lost_q;

    // Window-close intermediates
    logic [CNT_W-1:0]        up_final;
    logic [CNT_W-1:0]        dwn_final;
    logic signed [ERR_W-1:0] err;
    logic [ERR_W-1:0]        err_mag;
    logic                    sat;
    logic                    in_tol;
    logic                    out_tol;
    logic [RUN_W-1:0]        run_inc;
    logic                    tmo_hit;

    tdc_therm2bin #(
        .W (N_TDC)
    ) u_up_cnt (
        .clk     (clk),
        .reset   (reset),
        .code_i  (up_error),
        .count_o (up_cnt)
    );

    tdc_therm2bin #(
        .W (N_TDC)
    ) u_dwn_cnt (
        .clk     (clk),
        .reset   (reset),
        .code_i  (dwn_error),
        .count_o (dwn_cnt)
    );

    always_comb begin
        // The count arriving with ref_d_q belongs to the window being closed.
        up_final  = (up_cnt > up_peak_q) ? up_cnt : up_peak_q;
        dwn_final = (dwn_cnt > dwn_peak_q) ? dwn_cnt : dwn_peak_q;
        err       = ERR_W'(up_final) - ERR_W'(dwn_final);
        err_mag   = abs_err(err);
        sat       = (up_final == CntFull) || (dwn_final == CntFull);
        in_tol    = (err_mag <= ERR_W'(LOCK_TOL)) && !sat;
        out_tol   = (err_mag > ERR_W'(UNLOCK_TOL)) || sat;
        run_inc   = run_q + RUN_W'(1);
        tmo_hit   = !ref_edge && (tmo_q == TmoLast);

        state_d     = state_q;
        settle_d    = settle_q;
        run_d       = run_q;
        phase_err_d = phase_err_q;
        err_valid_d = 1'b0;
        err_sat_d   = err_sat_q;
        locked_d    = locked_q;
        ref_lost_d  = ref_lost_q;

        // Edges seen while idle never open a measurement.
        ref_d_d    = ref_edge && enable && (state_q != StIdle);
        up_peak_d  = ref_d_q ? '0 : up_final;
        dwn_peak_d = ref_d_q ? '0 : dwn_final;

        if (ref_edge) begin
            tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end

        if (ref_edge) begin
            ref_lost_d = 1'b0;
        end

        if (!enable) begin
            // Drops any partial window and any close still in flight.
            state_d    = StIdle;
            settle_d   = '0;
            run_d      = '0;
            tmo_d      = '0;
            err_sat_d  = 1'b0;
            locked_d   = 1'b0;
            ref_lost_d = 1'b0;
            up_peak_d  = '0;
            dwn_peak_d = '0;
        end else if (state_q == StIdle) begin
            state_d    = StSettle;
            settle_d   = '0;
            run_d      = '0;
            tmo_d      = '0;
            up_peak_d  = '0;
            dwn_peak_d = '0;
        end else if (tmo_hit) begin
            // Counter saturates at TmoMax, so this fires once per outage.
            state_d    = StSettle;
            settle_d   = '0;
            run_d      = '0;
            locked_d   = 1'b0;
            ref_lost_d = 1'b1;
            up_peak_d  = '0;
            dwn_peak_d = '0;
        end else if (ref_d_q) begin
            case (state_q)
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        state_d  = StTrack;
                        settle_d = '0;
                        run_d    = '0;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                StTrack: begin
                    err_valid_d = 1'b1;
                    phase_err_d = err;
                    err_sat_d   = sat;
                    if (!in_tol) begin
                        run_d = '0;
                    end else if (run_inc == RunLock) begin
                        state_d  = StLocked;
                        locked_d = 1'b1;
                        run_d    = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                StLocked: begin
                    err_valid_d = 1'b1;
                    phase_err_d = err;
                    err_sat_d   = sat;
                    if (out_tol) begin
                        state_d  = StTrack;
                        locked_d = 1'b0;
                        run_d    = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_d_q     <= 1'b0;
            up_peak_q   <= '0;
            dwn_peak_q  <= '0;
            state_q     <= StIdle;
            settle_q    <= '0;
            run_q       <= '0;
            tmo_q       <= '0;
            phase_err_q <= '0;
            err_valid_q <= 1'b0;
            err_sat_q   <= 1'b0;
            locked_q    <= 1'b0;
            ref_lost_q  <= 1'b0;
        end else begin
            ref_d_q     <= ref_d_d;
            up_peak_q   <= up_peak_d;
            dwn_peak_q  <= dwn_peak_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            run_q       <= run_d;
            tmo_q       <= tmo_d;
            phase_err_q <= phase_err_d;
            err_valid_q <= err_valid_d;
            err_sat_q   <= err_sat_d;
            locked_q    <= locked_d;
            ref_lost_q  <= ref_lost_d;
        end
    end

    assign phase_err = phase_err_q;
    assign err_valid = err_valid_q;
    assign err_sat   = err_sat_q;
    assign locked    = locked_q;
    assign ref_lost  = ref_lost_q;
    assign state     = state_q;

endmodule

// File: doc/tdc_pd_ctrl.md
Name: tdc_pd_ctrl

Overview:
- Measurement controller for the 32-stage thermometer-coded TDC phase detector.
- Once per reference period it converts the UP/DWN thermometer codes to a signed binary phase error and issues a one-cycle valid strobe.
- Sequences settle, track and lock phases, runs the lock detector, and flags loss of reference.
- Sits between the TDC and the digital loop filter; all logic runs on the TDC sampling clock.

Parameters:
- N_TDC, 32, thermometer code length (count range 0..N_TDC).
- SETTLE_PERIODS, 4, reference periods discarded after enable.
- LOCK_TOL, 2, |error| at or below this counts toward lock.
- UNLOCK_TOL, 4, |error| above this while locked drops lock (UNLOCK_TOL >= LOCK_TOL).
- LOCK_COUNT, 16, consecutive in-tolerance measurements needed to lock.
- REF_TIMEOUT, 1024, clk cycles without ref_edge before ref_lost.

Ports:
- clk, in, 1, TDC sampling clock.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, run controller; low forces IDLE.
- ref_edge, in, 1, one-cycle pulse per clk_ref rising edge, already synchronised to clk.
- up_error, in, N_TDC, UP thermometer code.
- dwn_error, in, N_TDC, DWN thermometer code.
- phase_err, out, 7, signed, up_peak minus dwn_peak.
- err_valid, out, 1, one-cycle strobe qualifying phase_err.
- err_sat, out, 1, the measurement on phase_err had a peak equal to N_TDC.
- locked, out, 1, lock indicator.
- ref_lost, out, 1, sticky reference-timeout flag, cleared on the next ref_edge.
- state, out, 2, IDLE=0, SETTLE=1, TRACK=2, LOCKED=3.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and peaks 0.
- Stage 1 (registered):
  - up_cnt and dwn_cnt are the popcounts of the input codes (bubble-tolerant, 6 bits, 0..32).
  - ref_edge is delayed one cycle (ref_d) to align with the counts.
- Stage 2, peak tracking:
  - up_peak and dwn_peak hold the maximum count since the last window close.
  - On ref_d, the window closes using max(peak, current count). phase_err = up_final − dwn_final (range −32..+32, 7-bit two's complement). err_sat = (up_final == N_TDC) or (dwn_final == N_TDC).
  - In the same cycle as the close, both peaks clear to 0.
- Latency and strobe:
  - err_valid rises exactly 2 clk cycles after the ref_edge input and lasts 1 cycle.
  - err_valid is asserted only in TRACK or LOCKED.
  - phase_err and err_sat hold their value until the next valid strobe.
- FSM:
  - IDLE: entered when enable=0 (takes priority over everything). Clears the lock counter, locked and peaks. Moves to SETTLE when enable=1.
  - SETTLE: counts closed windows. After SETTLE_PERIODS windows, moves to TRACK. No err_valid in this state.
  - TRACK: if |err| <= LOCK_TOL and not saturated, increment run_cnt; otherwise run_cnt = 0. When run_cnt reaches LOCK_COUNT, move to LOCKED and set locked=1 in the same cycle as that err_valid.
  - LOCKED: if |err| > UNLOCK_TOL or saturated, move to TRACK, set locked=0 and run_cnt=0.
- Timeout:
  - A cycle counter resets on each ref_edge.
  - On reaching REF_TIMEOUT, ref_lost=1, the FSM moves to SETTLE, locked=0 and the peaks clear.
  - ref_lost clears on the next ref_edge; the timeout counter saturates.
- enable deassert mid-window: the partial window is discarded and no err_valid is produced.
- A ref_edge in IDLE is ignored.

Decomposition:
- Shared package (tdc_pkg): N_TDC, state encoding enum, and the error width constant localparam ERR_W = $clog2(N_TDC)+2.
- One sub-module: tdc_therm2bin, a registered popcount of an N_TDC-bit code with a 1-cycle latency. It is instantiated twice.

Test Plan:
- Reset, then enable, then 4 ref_edges with any codes → no err_valid; state goes 1 then 2.
- In TRACK, up code 0x0000_00FF peak with dwn 0 → phase_err=+8, err_valid 2 cycles after ref_edge, err_sat=0.
- dwn code peak 0xFFFF_FFFF with up 0x3 → phase_err=−30, err_sat=1, run_cnt cleared.
- 16 consecutive windows with error +1 → locked=1 on the 16th strobe, state=3. Then one window with +5 → locked=0, state=2.
- No ref_edge for 1024 cycles while LOCKED → ref_lost=1, locked=0, state=1. The next ref_edge clears ref_lost.
- enable dropped 1 cycle after ref_edge → no err_valid follows; state=0 and all flags 0 on the next cycle.
